// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared constants, repeat FSM states and width helpers for the button front end
package pong_pkg;

  // Button channel indices on the btn_* vectors
  localparam int BTN_U = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int BTN_D = 3;
  localparam int BTN_C = 4;

  // Auto-repeat state machine encoding
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - pad-side inputs and conditioned outputs of the button front end
interface btn_conditioner_if #(
  parameter int N_BTN = 5
);

  logic [N_BTN-1:0] btn_raw;
  logic             frame_tick;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;
  logic [N_BTN-1:0] btn_frame_press;

  // Board / video side: drives pads and frame strobe, consumes the clean events
  modport master (
    output btn_raw,
    output frame_tick,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat,
    input  btn_frame_press
  );

  // Conditioner side
  modport slave (
    input  btn_raw,
    input  frame_tick,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat,
    output btn_frame_press
  );

endinterface

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchroniser, debounce, edge pulses, auto-repeat and frame latch
module btn_channel
  import pong_pkg::*;
#(
  parameter int DB_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic frame_tick,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat,
  output logic btn_frame_press
);

  localparam int DB_W    = cnt_width(DB_CYCLES);
  localparam int RPT_MAX = max2(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RPT_W   = cnt_width(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [DB_W-1:0]  db_cnt_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             release_q;
  logic             pending_q;
  rpt_state_t       state_q;
  rpt_state_t       state_n;
  logic [RPT_W-1:0] rpt_cnt_q;
  logic [RPT_W-1:0] rpt_cnt_n;
  logic             rpt_pulse;

  // Two-flop synchroniser bringing the asynchronous pad into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed from the current one for DB_CYCLES cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else if (sync_q2 == level_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_q  <= sync_q2;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  // Registered single-cycle press/release pulses, one cycle after the level edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_d   <= level_q;
      press_q   <= level_q & ~level_d;
      release_q <= ~level_q & level_d;
    end
  end

  // Repeat FSM state and hold-time counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RPT_IDLE;
      rpt_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      rpt_cnt_q <= rpt_cnt_n;
    end
  end

  // Repeat FSM: first pulse with the press, then after the delay, then every period while held
  always_comb begin
    state_n   = state_q;
    rpt_cnt_n = rpt_cnt_q;
    rpt_pulse = 1'b0;
    if (!level_q) begin
      state_n   = RPT_IDLE;
      rpt_cnt_n = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          if (press_q) begin
            rpt_pulse = 1'b1;
            state_n   = RPT_DELAY;
            rpt_cnt_n = '0;
          end
        end
        RPT_DELAY: begin
          if (rpt_cnt_q == DELAY_LAST) begin
            rpt_pulse = 1'b1;
            state_n   = RPT_REPEAT;
            rpt_cnt_n = '0;
          end else begin
            rpt_cnt_n = rpt_cnt_q + RPT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (rpt_cnt_q == PERIOD_LAST) begin
            rpt_pulse = 1'b1;
            rpt_cnt_n = '0;
          end else begin
            rpt_cnt_n = rpt_cnt_q + RPT_W'(1);
          end
        end
        default: begin
          state_n   = RPT_IDLE;
          rpt_cnt_n = '0;
        end
      endcase
    end
  end

  // Remember a press until the next frame strobe; a press on the strobe itself is not kept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
    end else if (frame_tick) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_q | press_q;
    end
  end

  assign btn_level       = level_q;
  assign btn_press       = press_q;
  assign btn_release     = release_q;
  assign btn_repeat      = rpt_pulse;
  assign btn_frame_press = frame_tick & (pending_q | press_q);

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - five-button front end: one independent conditioning channel per pad
module btn_conditioner
  import pong_pkg::*;
#(
  parameter int N_BTN         = 5,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input logic          clk,
  input logic          reset,
  btn_conditioner_if.slave bus
);

  // One channel per button; they share only the clock, reset and frame strobe
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .btn_raw        (bus.btn_raw[g]),
      .frame_tick     (bus.frame_tick),
      .btn_level      (bus.btn_level[g]),
      .btn_press      (bus.btn_press[g]),
      .btn_release    (bus.btn_release[g]),
      .btn_repeat     (bus.btn_repeat[g]),
      .btn_frame_press(bus.btn_frame_press[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed and randomized check of btn_conditioner against a behavioural model
module tb_btn_conditioner;
  import pong_pkg::*;

  localparam int N    = 5;
  localparam int DB   = 4;
  localparam int RD   = 20;
  localparam int RP   = 8;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN        (N),
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = -1;

  // Model history, indexed by cycle
  logic [N-1:0] raw_h [MAXC];
  logic [N-1:0] lvl_h [MAXC];
  bit           rst_h [MAXC];
  int p_hold [N];   // cycle of press that started the current hold, -1 if not held
  int lp     [N];   // cycle of last press
  int lt;           // cycle of last frame tick (or reset)

  // Observation trackers for directed scenarios
  int first_lvl [N];
  int first_prs [N];
  int first_rel [N];
  int prs_cnt   [N];
  int rel_cnt   [N];
  int rep_cnt   [N];
  int fp_cnt    [N];
  int rep_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] lvl_at(input int t);
    if (t < 0) return '0;
    return lvl_h[t];
  endfunction

  // Synchronised view of the pad: two cycles late, zero while reset is recent
  function automatic logic [N-1:0] sync_at(input int t);
    if (t < 2) return '0;
    if (rst_h[t] || rst_h[t-1] || rst_h[t-2]) return '0;
    return raw_h[t-2];
  endfunction

  task automatic clear_trk();
    for (int i = 0; i < N; i++) begin
      first_lvl[i] = -1; first_prs[i] = -1; first_rel[i] = -1;
      prs_cnt[i] = 0; rel_cnt[i] = 0; rep_cnt[i] = 0; fp_cnt[i] = 0;
    end
    rep_q.delete();
  endtask

  task automatic step(input logic [N-1:0] raw, input logic tick, input logic rst_v);
    logic [N-1:0] e_lvl, e_pr, e_rl, e_rep, e_fp, prev, prev2, s;
    logic flip;
    int d;
    @(posedge clk);
    #1;
    bus.btn_raw    = raw;
    bus.frame_tick = tick;
    reset          = rst_v;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    raw_h[cyc] = raw;
    rst_h[cyc] = rst_v;
    e_lvl = '0; e_pr = '0; e_rl = '0; e_rep = '0; e_fp = '0;
    if (rst_v) begin
      for (int i = 0; i < N; i++) begin p_hold[i] = -1; lp[i] = -1; end
      lt = cyc;
    end else begin
      prev  = lvl_at(cyc - 1);
      prev2 = lvl_at(cyc - 2);
      for (int i = 0; i < N; i++) begin
        flip = 1'b1;
        for (int k = 1; k <= DB; k++) begin
          s = sync_at(cyc - k);
          if (cyc - k < 0 || s[i] == prev[i]) flip = 1'b0;
        end
        e_lvl[i] = flip ? ~prev[i] : prev[i];
      end
      e_pr = prev & ~prev2;
      e_rl = ~prev & prev2;
      for (int i = 0; i < N; i++) begin
        if (e_pr[i]) p_hold[i] = cyc;
        if (!e_lvl[i]) p_hold[i] = -1;
        d = cyc - p_hold[i];
        e_rep[i] = e_pr[i] | (p_hold[i] >= 0 && d >= RD && ((d - RD) % RP) == 0);
        if (e_pr[i]) lp[i] = cyc;
        e_fp[i] = tick && (lp[i] > lt);
      end
      if (tick) lt = cyc;
    end
    lvl_h[cyc] = e_lvl;
    @(negedge clk);
    check_eq("level",       32'(bus.btn_level),       32'(e_lvl));
    check_eq("press",       32'(bus.btn_press),       32'(e_pr));
    check_eq("release",     32'(bus.btn_release),     32'(e_rl));
    check_eq("repeat",      32'(bus.btn_repeat),      32'(e_rep));
    check_eq("frame_press", 32'(bus.btn_frame_press), 32'(e_fp));
    for (int i = 0; i < N; i++) begin
      if (bus.btn_level[i] && first_lvl[i] < 0) first_lvl[i] = cyc;
      if (bus.btn_press[i]) begin prs_cnt[i]++; if (first_prs[i] < 0) first_prs[i] = cyc; end
      if (bus.btn_release[i]) begin rel_cnt[i]++; if (first_rel[i] < 0) first_rel[i] = cyc; end
      if (bus.btn_repeat[i]) rep_cnt[i]++;
      if (bus.btn_frame_press[i]) fp_cnt[i]++;
    end
    if (bus.btn_repeat[BTN_D]) rep_q.push_back(cyc);
  endtask

  task automatic hold(input logic [N-1:0] raw, input logic tick, input int n);
    for (int j = 0; j < n; j++) step(raw, tick, 1'b0);
  endtask

  initial begin
    logic [N-1:0] b0, b1, b2, b3, b4, rv;
    int r, rr, ntick, rst_left;
    int dur [N];
    int exp_off [6];
    exp_off = '{0, 20, 28, 36, 44, 52};
    b0 = '0; b0[BTN_U] = 1'b1;
    b1 = '0; b1[BTN_L] = 1'b1;
    b2 = '0; b2[BTN_R] = 1'b1;
    b3 = '0; b3[BTN_D] = 1'b1;
    b4 = '0; b4[BTN_C] = 1'b1;
    reset = 1'b1;
    bus.btn_raw = '0;
    bus.frame_tick = 1'b0;
    for (int i = 0; i < N; i++) begin p_hold[i] = -1; lp[i] = -1; end
    lt = -1;
    clear_trk();

    // Reset, including a frame tick and a pressed pad while held in reset
    step('0, 1'b0, 1'b1);
    step(b4, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    hold('0, 1'b0, 6);

    // Clean press on C
    clear_trk();
    r = cyc + 1;
    hold(b4, 1'b0, 12);
    check_eq("s1_level_latency", 32'(first_lvl[BTN_C] - r), 32'd6);
    check_eq("s1_press_latency", 32'(first_prs[BTN_C] - r), 32'd7);
    check_eq("s1_press_count",   32'(prs_cnt[BTN_C]), 32'd1);
    check_eq("s1_repeat_count",  32'(rep_cnt[BTN_C]), 32'd1);
    hold('0, 1'b0, 12);
    check_eq("s1_release_count", 32'(rel_cnt[BTN_C]), 32'd1);

    // Bounce on U
    clear_trk();
    hold(b0, 1'b0, 2); hold('0, 1'b0, 2); hold(b0, 1'b0, 2); hold('0, 1'b0, 2);
    r = cyc + 1;
    hold(b0, 1'b0, 12);
    check_eq("s2_press_count",   32'(prs_cnt[BTN_U]), 32'd1);
    check_eq("s2_release_count", 32'(rel_cnt[BTN_U]), 32'd0);
    check_eq("s2_press_latency", 32'(first_prs[BTN_U] - r), 32'd7);
    hold('0, 1'b0, 12);

    // Auto-repeat on D, held 60 cycles
    clear_trk();
    r = cyc + 1;
    hold(b3, 1'b0, 60);
    hold('0, 1'b0, 10);
    check_eq("s3_press_latency", 32'(first_prs[BTN_D] - r), 32'd7);
    check_eq("s3_repeat_count",  32'(rep_q.size()), 32'd6);
    for (int k = 0; k < 6 && k < rep_q.size(); k++)
      check_eq($sformatf("s3_repeat_off%0d", k), 32'(rep_q[k] - first_prs[BTN_D]), 32'(exp_off[k]));
    check_eq("s3_release_latency", 32'(first_rel[BTN_D] - (r + 60)), 32'd7);

    // Frame alignment on L
    clear_trk();
    hold('0, 1'b1, 1);
    hold(b1, 1'b0, 10); hold('0, 1'b0, 10); hold(b1, 1'b0, 10); hold('0, 1'b0, 10);
    hold('0, 1'b1, 1);
    check_eq("s4_two_presses", 32'(fp_cnt[BTN_L]), 32'd1);
    clear_trk();
    hold(b1, 1'b0, 7);
    step(b1, 1'b1, 1'b0);
    check_eq("s4_same_cycle", 32'(fp_cnt[BTN_L]), 32'd1);
    hold(b1, 1'b0, 5); hold('0, 1'b0, 12);
    hold('0, 1'b1, 1);
    check_eq("s4_no_press", 32'(fp_cnt[BTN_L]), 32'd1);

    // Reset while R is auto-repeating, pad still held
    clear_trk();
    hold(b2, 1'b0, 31);
    for (int j = 0; j < 3; j++) begin
      step(b2, 1'b0, 1'b1);
      check_eq("s5_outputs_in_reset",
               32'(bus.btn_level | bus.btn_press | bus.btn_release | bus.btn_repeat | bus.btn_frame_press), 32'd0);
    end
    clear_trk();
    rr = cyc + 1;
    hold(b2, 1'b0, 12);
    check_eq("s5_press_after_reset", 32'(first_prs[BTN_R] - rr), 32'd7);
    hold('0, 1'b0, 12);

    // Simultaneous U and D
    clear_trk();
    r = cyc + 1;
    hold(b0 | b3, 1'b0, 12);
    check_eq("s6_same_cycle",    32'(first_prs[BTN_U]), 32'(first_prs[BTN_D]));
    check_eq("s6_press_latency", 32'(first_prs[BTN_U] - r), 32'd7);
    check_eq("s6_others_quiet",  32'(prs_cnt[BTN_L] + prs_cnt[BTN_R] + prs_cnt[BTN_C]), 32'd0);
    hold('0, 1'b0, 12);

    // Randomized pads, frame ticks and occasional resets
    rv = '0;
    rst_left = 0;
    for (int i = 0; i < N; i++) dur[i] = 0;
    for (int j = 0; j < 4000; j++) begin
      for (int i = 0; i < N; i++) begin
        if (dur[i] == 0) begin
          rv[i] = ~rv[i];
          dur[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 60));
        end
        dur[i]--;
      end
      ntick = ($urandom_range(0, 15) == 0) ? 1 : 0;
      if (rst_left > 0) begin
        rst_left--;
        step(rv, ntick[0], 1'b1);
      end else begin
        if ($urandom_range(0, 999) == 0) rst_left = int'($urandom_range(1, 4));
        step(rv, ntick[0], 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
